// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-source register-file writeback arbiter with starvation guard
//
// Shares the register file's single synchronous write port between port A
// (in-order pipeline writeback, fixed priority) and port B (long-latency
// unit). B is forced to win after STARVE_MAX consecutive lost cycles. The
// winning write is registered once before driving the rf write port. Writes
// to x0 are accepted immediately and discarded without using the slot.
//
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_a_valid/i_a_waddr/i_a_wdata     port A request
//   o_a_ready                         port A accepted this cycle (combinational)
//   i_b_valid/i_b_waddr/i_b_wdata     port B request
//   o_b_ready                         port B accepted this cycle (combinational)
//   o_rd_wen/o_rd_waddr/o_rd_wdata    registered rf write port
//   o_b_forced                        starvation guard active this cycle
//   o_conflict_cnt                    saturating count of cycles with both ports contending

module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_a_valid,
    input  logic [4:0]       i_a_waddr,
    input  logic [31:0]      i_a_wdata,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [4:0]       i_b_waddr,
    input  logic [31:0]      i_b_wdata,
    output logic             o_b_ready,
    output logic             o_rd_wen,
    output logic [4:0]       o_rd_waddr,
    output logic [31:0]      o_rd_wdata,
    output logic             o_b_forced,
    output logic [CNT_W-1:0] o_conflict_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic       a_ev;
    logic       b_ev;
    logic       a_sink;
    logic       b_sink;
    logic       force_b;
    logic       grant_a;
    logic       grant_b;
    logic [3:0] starve_cnt;

    // Effective requests need a real destination; x0 requests are sunk.
    assign a_ev   = i_a_valid && (i_a_waddr != 5'd0);
    assign b_ev   = i_b_valid && (i_b_waddr != 5'd0);
    assign a_sink = i_a_valid && (i_a_waddr == 5'd0);
    assign b_sink = i_b_valid && (i_b_waddr == 5'd0);

    assign force_b = (starve_cnt == STARVE_LIM);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (b_ev && force_b) begin
            grant_b = 1'b1;
        end else if (a_ev) begin
            grant_a = 1'b1;
        end else if (b_ev) begin
            grant_b = 1'b1;
        end
    end

    // Readies are held low throughout reset so no request is consumed then.
    assign o_a_ready  = i_rst_n && (grant_a || a_sink);
    assign o_b_ready  = i_rst_n && (grant_b || b_sink);
    assign o_b_forced = force_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_wen   <= 1'b0;
            o_rd_waddr <= 5'd0;
            o_rd_wdata <= 32'd0;
        end else if (grant_a) begin
            o_rd_wen   <= 1'b1;
            o_rd_waddr <= i_a_waddr;
            o_rd_wdata <= i_a_wdata;
        end else if (grant_b) begin
            o_rd_wen   <= 1'b1;
            o_rd_waddr <= i_b_waddr;
            o_rd_wdata <= i_b_wdata;
        end else begin
            // Address/data hold so the rf port does not toggle when idle.
            o_rd_wen   <= 1'b0;
        end
    end

    // Counts consecutive cycles B wanted the slot but A took it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!b_ev || grant_b) begin
            starve_cnt <= 4'd0;
        end else if (grant_a && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_conflict_cnt <= '0;
        end else if (a_ev && b_ev && (o_conflict_cnt != {CNT_W{1'b1}})) begin
            o_conflict_cnt <= o_conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter

module tb_rf_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_a_valid = 1'b0;
    logic [4:0]  i_a_waddr = '0;
    logic [31:0] i_a_wdata = '0;
    logic        i_b_valid = 1'b0;
    logic [4:0]  i_b_waddr = '0;
    logic [31:0] i_b_wdata = '0;

    logic        o_a_ready, o_b_ready, o_rd_wen, o_b_forced;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;
    logic [15:0] o_conflict_cnt;

    logic        s_a_ready, s_b_ready, s_rd_wen, s_b_forced;
    logic [4:0]  s_rd_waddr;
    logic [31:0] s_rd_wdata;
    logic [1:0]  s_conflict_cnt;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    logic [31:0] rf[32];

    always #5 i_clk = ~i_clk;

    rf_wb_arbiter #(.STARVE_MAX(4), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_valid(i_a_valid), .i_a_waddr(i_a_waddr), .i_a_wdata(i_a_wdata), .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid), .i_b_waddr(i_b_waddr), .i_b_wdata(i_b_wdata), .o_b_ready(o_b_ready),
        .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata),
        .o_b_forced(o_b_forced), .o_conflict_cnt(o_conflict_cnt)
    );

    rf_wb_arbiter #(.STARVE_MAX(4), .CNT_W(2)) dut_small (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_valid(i_a_valid), .i_a_waddr(i_a_waddr), .i_a_wdata(i_a_wdata), .o_a_ready(s_a_ready),
        .i_b_valid(i_b_valid), .i_b_waddr(i_b_waddr), .i_b_wdata(i_b_wdata), .o_b_ready(s_b_ready),
        .o_rd_wen(s_rd_wen), .o_rd_waddr(s_rd_waddr), .o_rd_wdata(s_rd_wdata),
        .o_b_forced(s_b_forced), .o_conflict_cnt(s_conflict_cnt)
    );

    // Simple register file fed by the arbiter's write port.
    always @(posedge i_clk) begin
        if (o_rd_wen) rf[o_rd_waddr] <= o_rd_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every rf write must match the oldest expected write.
    always @(negedge i_clk) begin
        if (i_rst_n && o_rd_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=x%0d:%0h expected=none", o_rd_waddr, o_rd_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({o_rd_waddr, o_rd_wdata} !== e) begin
                    errors++;
                    $display("FAIL write actual=x%0d:%0h expected=x%0d:%0h",
                             o_rd_waddr, o_rd_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    // Drive one cycle of requests (called at posedge+1), check combinational
    // outputs at negedge, then queue the hand-predicted winner at the edge.
    task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic ear, input logic ebr, input logic ef, input string tag);
        i_a_valid = av; i_a_waddr = aa; i_a_wdata = ad;
        i_b_valid = bv; i_b_waddr = ba; i_b_wdata = bd;
        @(negedge i_clk);
        chk({tag, "_a_ready"}, 64'(o_a_ready), 64'(ear));
        chk({tag, "_b_ready"}, 64'(o_b_ready), 64'(ebr));
        chk({tag, "_b_forced"}, 64'(o_b_forced), 64'(ef));
        @(posedge i_clk);
        if (ear && aa != 5'd0) exp_q.push_back({aa, ad});
        else if (ebr && ba != 5'd0) exp_q.push_back({ba, bd});
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_0000 + 32'(i);

        // Reset state, with requests pending: readies must stay low.
        i_a_valid = 1'b1; i_a_waddr = 5'd3; i_b_valid = 1'b1; i_b_waddr = 5'd4;
        #2;
        chk("rst_a_ready", 64'(o_a_ready), 64'd0);
        chk("rst_b_ready", 64'(o_b_ready), 64'd0);
        chk("rst_wen", 64'(o_rd_wen), 64'd0);
        chk("rst_waddr", 64'(o_rd_waddr), 64'd0);
        chk("rst_wdata", 64'(o_rd_wdata), 64'd0);
        chk("rst_conflict", 64'(o_conflict_cnt), 64'd0);
        i_a_valid = 1'b0; i_b_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // A only: x5 = 0x1234.
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "a_only");
        // Idle: wen drops, address/data hold, rf keeps x5.
        idle("idle1");
        chk("idle_wen", 64'(o_rd_wen), 64'd0);
        chk("idle_waddr", 64'(o_rd_waddr), 64'd5);
        chk("idle_wdata", 64'(o_rd_wdata), 64'h1234);
        chk("rf_x5", 64'(rf[5]), 64'h1234);

        // A to x0 sunk alongside B x7: both ready, only x7 written.
        cycle(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b0, "x0_sink");
        idle("idle2");
        chk("rf_x7", 64'(rf[7]), 64'h77);
        chk("rf_x0", 64'(rf[0]), 64'hDEAD_0000);

        // Contention: A wins four times, B forced on the fifth, then A alone.
        for (int k = 1; k <= 4; k++)
            cycle(1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'd2, 32'hB2, 1'b1, 1'b0, 1'b0, "contend");
        cycle(1'b1, 5'd1, 32'h105, 1'b1, 5'd2, 32'hB2, 1'b0, 1'b1, 1'b1, "forced");
        cycle(1'b1, 5'd1, 32'h105, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "after_force");
        idle("idle3");
        chk("conflict_cnt", 64'(o_conflict_cnt), 64'd5);
        chk("conflict_sat", 64'(s_conflict_cnt), 64'd3);
        chk("rf_x1", 64'(rf[1]), 64'h105);
        chk("rf_x2", 64'(rf[2]), 64'hB2);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // Async reset while a write is presented: it must vanish before the edge.
        i_a_valid = 1'b1; i_a_waddr = 5'd9; i_a_wdata = 32'hBEEF;
        @(posedge i_clk); #1;
        i_a_valid = 1'b0;
        chk("pre_rst_wen", 64'(o_rd_wen), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(o_rd_wen), 64'd0);
        chk("mid_rst_waddr", 64'(o_rd_waddr), 64'd0);
        chk("mid_rst_wdata", 64'(o_rd_wdata), 64'd0);
        chk("mid_rst_conflict", 64'(o_conflict_cnt), 64'd0);
        chk("mid_rst_conflict_s", 64'(s_conflict_cnt), 64'd0);
        @(posedge i_clk); #1;
        chk("rf_x9", 64'(rf[9]), 64'hDEAD_0009);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // After reset the starvation count is zero: B only gets forced after four losses.
        for (int k = 0; k < 4; k++)
            cycle(1'b1, 5'd10, 32'h200 + 32'(k), 1'b1, 5'd11, 32'hB11, 1'b1, 1'b0, 1'b0, "post_rst");
        cycle(1'b1, 5'd10, 32'h204, 1'b1, 5'd11, 32'hB11, 1'b0, 1'b1, 1'b1, "post_rst_f");
        idle("idle4");
        idle("idle5");
        chk("post_conflict", 64'(o_conflict_cnt), 64'd5);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
